// File: rtl/gain_stream_mc.sv
// rtl/gain_stream_mc.sv - multi-channel gain stage with round/saturate and output FIFO
//
// Purpose:
//   Takes a round-robin interleaved sample stream and multiplies each sample by
//   the gain of its channel. The product is rounded half-up, shifted down by
//   FRAC_BITS and saturated to DATA_WIDTH. Results go into an output FIFO with
//   first-word fall-through, and each result carries its channel tag.
//   The pipeline never stalls. in_full stops new samples early enough that every
//   in-flight sample is sure to have a FIFO slot.
//
// Ports:
//   clock, reset           single rising-edge clock; asynchronous active-low reset
//   din, in_wr_en, in_full sample input; a sample is taken when in_wr_en && !in_full
//   gain_wr_en, gain_ch,   per-channel gain write (signed fixed point with
//   gain_din               FRAC_BITS fractional bits); it takes effect on the next edge
//   dout, dout_ch,         head of the FIFO and its channel tag; valid while !out_empty
//   out_rd_en, out_empty   pop request and FIFO empty indication
//   sat_flag, sat_clr      sticky saturation indication and its clear
`timescale 1ns/1ps
module gain_stream_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_wr_en,
  output logic                  in_full,
  input  logic                  gain_wr_en,
  input  logic [CH_W-1:0]       gain_ch,
  input  logic [GAIN_WIDTH-1:0] gain_din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CH_W-1:0]       dout_ch,
  input  logic                  out_rd_en,
  output logic                  out_empty,
  output logic                  sat_flag,
  input  logic                  sat_clr
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(1) << FRAC_BITS;
  localparam logic signed [PW-1:0]  RND      = PW'(1) << (FRAC_BITS - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [GAIN_WIDTH-1:0] gain [NUM_CH];
  logic [CH_W-1:0]       ch_cnt;

  logic                  s1_valid;
  logic signed [PW-1:0]  s1_prod;
  logic [CH_W-1:0]       s1_ch;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [CH_W-1:0]       s2_ch;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]       mem_ch   [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [CH_W-1:0]       hold_ch;

  logic                    accept;
  logic                    push;
  logic                    pop;
  logic signed [DATA_WIDTH-1:0] din_s;
  logic signed [GAIN_WIDTH-1:0] gain_s;
  logic signed [PW-1:0]    prod_c;
  logic signed [PW-1:0]    rounded;
  logic [PW-DATA_WIDTH:0]  hi_bits;
  logic                    clip;
  logic [DATA_WIDTH-1:0]   sat_val;
  logic [1:0]              inflight;
  logic [AW+1:0]           credit;

  // The gain read here is the value before any write on this edge, so a
  // sample taken in the same cycle as a gain write uses the old gain.
  assign accept = in_wr_en && !in_full;
  assign din_s  = din;
  assign gain_s = gain[ch_cnt];
  assign prod_c = PW'(din_s) * PW'(gain_s);

  // The result fits DATA_WIDTH only if every bit above the result sign bit
  // matches the sign bit.
  assign rounded = (s1_prod + RND) >>> FRAC_BITS;
  assign hi_bits = rounded[PW-1:DATA_WIDTH-1];
  assign clip    = !((&hi_bits) || !(|hi_bits));
  assign sat_val = clip ? (rounded[PW-1] ? SAT_MIN : SAT_MAX) : rounded[DATA_WIDTH-1:0];

  // in_full counts the samples still in the pipeline, so a FIFO slot is held for each of them.
  assign push      = s2_valid;
  assign out_empty = (count == '0);
  assign pop       = out_rd_en && !out_empty;
  assign inflight  = {1'b0, s1_valid} + {1'b0, s2_valid};
  assign credit    = (AW+2)'(count) + (AW+2)'(inflight);
  assign in_full   = (credit >= (AW+2)'(FIFO_DEPTH));

  // First-word fall-through. When the FIFO is empty the outputs show the last
  // word popped, or 0 after reset.
  assign dout    = out_empty ? hold_data : mem_data[rd_ptr];
  assign dout_ch = out_empty ? hold_ch   : mem_ch[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) gain[i] <= GAIN_ONE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gain_wr_en && gain_ch == CH_W'(i)) gain[i] <= gain_din;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch_cnt   <= '0;
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_ch    <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ch    <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (accept) begin
        ch_cnt <= (ch_cnt == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt + CH_W'(1);
      end
      s1_valid <= accept;
      if (accept) begin
        s1_prod <= prod_c;
        s1_ch   <= ch_cnt;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sat_val;
        s2_ch   <= s1_ch;
      end
      // If a set and a clear happen in the same cycle, the set wins.
      if (s1_valid && clip) sat_flag <= 1'b1;
      else if (sat_clr)     sat_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
      hold_ch   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        hold_data <= mem_data[rd_ptr];
        hold_ch   <= mem_ch[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The storage array has no reset. It is read only while count is non-zero,
  // so old contents are never visible.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= s2_data;
      mem_ch[wr_ptr]   <= s2_ch;
    end
  end

endmodule

// File: tb/tb_gain_stream_mc.sv
// tb/tb_gain_stream_mc.sv - scoreboard testbench for gain_stream_mc
`timescale 1ns/1ps
module tb_gain_stream_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] din = '0;
  logic        in_wr_en = 1'b0;
  logic        in_full;
  logic        gain_wr_en = 1'b0;
  logic [0:0]  gain_ch = '0;
  logic [15:0] gain_din = '0;
  logic [31:0] dout;
  logic [0:0]  dout_ch;
  logic        out_rd_en = 1'b0;
  logic        out_empty;
  logic        sat_flag;
  logic        sat_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q [$];
  logic [15:0] mgain [2];
  logic        mch;

  gain_stream_mc dut (
    .clock(clock), .reset(reset), .din(din), .in_wr_en(in_wr_en), .in_full(in_full),
    .gain_wr_en(gain_wr_en), .gain_ch(gain_ch), .gain_din(gain_din),
    .dout(dout), .dout_ch(dout_ch), .out_rd_en(out_rd_en), .out_empty(out_empty),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [15:0] g);
    longint p;
    p = longint'($signed(d)) * longint'($signed(g));
    p = (p + 64'sd512) >>> 10;
    if (p > 64'sd2147483647)       return 32'h7FFF_FFFF;
    else if (p < -64'sd2147483648) return 32'h8000_0000;
    else                           return p[31:0];
  endfunction

  always @(negedge clock) begin : monitor
    logic [32:0] e;
    if (reset && out_rd_en && !out_empty) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("dout", dout, e[31:0]);
        check("dout_ch", dout_ch, e[32]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] want, output bit ok);
    din      = d;
    in_wr_en = 1'b1;
    ok       = !in_full;
    if (ok) begin
      exp_q.push_back({mch, want});
      mch = ~mch;
    end
    step();
    in_wr_en = 1'b0;
  endtask

  task automatic push_m(input logic [31:0] d, output bit ok);
    push(d, model(d, mgain[mch]), ok);
  endtask

  task automatic gw(input logic ch, input logic [15:0] g);
    gain_wr_en = 1'b1;
    gain_ch    = ch;
    gain_din   = g;
    step();
    gain_wr_en = 1'b0;
    mgain[ch]  = g;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_out_empty", out_empty, 1);
    check("rst_in_full", in_full, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_ch", dout_ch, 0);
    check("rst_sat_flag", sat_flag, 0);
    step();
    step();
    reset = 1'b1;
    exp_q.delete();
    mgain[0] = 16'h0400;
    mgain[1] = 16'h0400;
    mch = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_rd_en = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    out_rd_en = 1'b0;
    check("drain_left", exp_q.size(), 0);
    check("drain_empty", out_empty, 1);
  endtask

  initial begin : main
    bit ok;
    int acc;
    logic [31:0] d;
    bit do_gw;
    logic g_ch;
    logic [15:0] g_val;

    // 1: default gains, tags, latency, dout hold after emptying
    do_reset();
    push(32'd100, 32'd100, ok);
    push(32'hFFFF_FFF9, 32'hFFFF_FFF9, ok);
    check("lat_n2_empty", out_empty, 1);
    push(32'd3, 32'd3, ok);
    check("lat_n3_empty", out_empty, 0);
    drain();
    check("hold_dout", dout, 3);
    check("hold_dout_ch", dout_ch, 0);

    // 2: per-channel gains and round-half-up
    do_reset();
    gw(1'b1, 16'h0200);
    gw(1'b0, 16'h0C00);
    push(32'd10, 32'd30, ok);
    push(32'd10, 32'd5, ok);
    push(32'd0, 32'd0, ok);
    push(32'd3, 32'd2, ok);
    drain();
    check("no_sat", sat_flag, 0);

    // 3: saturation at both rails, sticky flag and its clear
    do_reset();
    gw(1'b0, 16'h7FFF);
    push(32'h7FFF_FFFF, 32'h7FFF_FFFF, ok);
    push(32'd0, 32'd0, ok);
    push(32'h8000_0000, 32'h8000_0000, ok);
    drain();
    check("sat_set", sat_flag, 1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_cleared", sat_flag, 0);

    // 4: backpressure: full after exactly FIFO_DEPTH accepted, drop while full
    do_reset();
    acc = 0;
    for (int i = 0; i < 40 && !in_full; i++) begin
      push_m($urandom, ok);
      if (ok) acc++;
    end
    check("accepted_until_full", acc, 16);
    check("in_full_high", in_full, 1);
    push_m(32'h1234_5678, ok);
    check("drop_when_full", ok, 0);
    step();
    step();
    step();
    check("in_full_held", in_full, 1);
    drain();
    check("in_full_released", in_full, 0);

    // 5: streaming with random gain writes (old-gain rule via model)
    do_reset();
    acc = 0;
    out_rd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      d     = $urandom;
      do_gw = ($urandom_range(0, 3) == 0);
      g_ch  = 1'($urandom_range(0, 1));
      g_val = 16'($urandom);
      din        = d;
      in_wr_en   = 1'b1;
      gain_wr_en = do_gw;
      gain_ch    = g_ch;
      gain_din   = g_val;
      if (!in_full) begin
        exp_q.push_back({mch, model(d, mgain[mch])});
        mch = ~mch;
        acc++;
      end
      step();
      if (do_gw) mgain[g_ch] = g_val;
    end
    in_wr_en   = 1'b0;
    gain_wr_en = 1'b0;
    check("stream_accepted", acc, 1000);
    drain();

    // 6: reset mid-burst with 5 in flight, then restart on channel 0
    do_reset();
    for (int i = 0; i < 5; i++) push_m($urandom, ok);
    do_reset();
    push_m(32'd77, ok);
    push_m(32'd78, ok);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
